// File: rtl/vec_play_capture_pkg.sv
// Shared definitions for the vector play/capture stage.
// Contents: FSM state encoding, load-select constants, default sizes.
package vec_play_capture_pkg;

  localparam int DEF_W     = 2;
  localparam int DEF_DEPTH = 4;

  localparam logic LOAD_SEL_STIM = 1'b0;
  localparam logic LOAD_SEL_EXP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vec_play_capture_mem.sv
// DEPTH x W register array with one synchronous write port, one
// asynchronous read port and a synchronous clear (clear wins over write).
// Ports:
//   clk_i    clock
//   clr_i    synchronous clear of every entry
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data (pre-write value in a write cycle)
module vec_mem #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vec_play_capture.sv
// Clocked stimulus/response stage around a combinational datapath.
// Plays stimulus vectors from a loaded memory into the datapath one per
// cycle, captures the datapath output into a result memory, and counts
// results that differ from a loaded expected memory.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   load_en/load_sel/load_addr/load_data  memory load (sel 0 stim, 1 exp)
//   num_vec, start                 run length (sampled on start), run request
//   dut_in, dut_valid, dut_out     datapath drive / capture
//   busy, done, mismatch_cnt       status
//   rd_addr, rd_data               result readout (combinational)
//
// Handshake: start is a one-cycle request honoured only in IDLE or DONE;
// dut_valid is high exactly for the cycles in which dut_in carries a live
// vector, and dut_out is captured on the rising edge closing each such cycle
// (no backpressure, the datapath is assumed combinational).
module vec_play_capture
  import vec_play_capture_pkg::*;
#(
  parameter  int W     = DEF_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_sel,
  input  logic [AW-1:0] load_addr,
  input  logic [W-1:0]  load_data,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  output logic [W-1:0]  dut_in,
  output logic          dut_valid,
  input  logic [W-1:0]  dut_out,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   mismatch_cnt,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   n_lat_q, n_lat_d;
  logic [AW:0]   mm_q, mm_d;

  logic [W-1:0]  stim_rd, exp_rd;
  logic          in_run;
  logic          load_ok;
  logic [AW:0]   num_clamp;

  assign in_run    = (state_q == ST_RUN);
  // Loads are dropped while a run is in flight so the vectors being played
  // cannot change underneath it.
  assign load_ok   = load_en && !in_run;
  assign num_clamp = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;

  vec_mem #(.W(W), .DEPTH(DEPTH)) u_stim (
    .clk_i   (clk),
    .clr_i   (1'b0),
    .we_i    (load_ok && (load_sel == LOAD_SEL_STIM)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (idx_q),
    .rdata_o (stim_rd)
  );

  vec_mem #(.W(W), .DEPTH(DEPTH)) u_exp (
    .clk_i   (clk),
    .clr_i   (1'b0),
    .we_i    (load_ok && (load_sel == LOAD_SEL_EXP)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (idx_q),
    .rdata_o (exp_rd)
  );

  vec_mem #(.W(W), .DEPTH(DEPTH)) u_res (
    .clk_i   (clk),
    .clr_i   (rst),
    .we_i    (in_run),
    .waddr_i (idx_q),
    .wdata_i (dut_out),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_lat_d = n_lat_q;
    mm_d    = mm_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d = '0;
          mm_d  = '0;
          if (num_vec == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            n_lat_d = num_clamp;
          end
        end
      end
      ST_RUN: begin
        // The count cannot pass DEPTH since a run is at most DEPTH vectors;
        // the guard just keeps it pinned there.
        if ((dut_out != exp_rd) && (mm_q != DEPTH_C)) mm_d = mm_q + 1'b1;
        idx_d = idx_q + 1'b1;
        if ({1'b0, idx_q} == (n_lat_q - 1'b1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_lat_q <= '0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_lat_q <= n_lat_d;
      mm_q    <= mm_d;
    end
  end

  assign dut_in       = in_run ? stim_rd : '0;
  assign dut_valid    = in_run;
  assign busy         = in_run;
  assign done         = (state_q == ST_DONE);
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_vec_play_capture.sv
// Bench for vec_play_capture driving a 2-bit decrement datapath model.
module tb_vec_play_capture;

  localparam int W     = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic          load_sel = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic [AW:0]   num_vec = '0;
  logic          start = 1'b0;
  logic [W-1:0]  dut_in;
  logic          dut_valid;
  logic [W-1:0]  dut_out;
  logic          busy;
  logic          done;
  logic [AW:0]   mismatch_cnt;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;

  // Datapath under test: 2-bit decrement.
  assign dut_out = W'(dut_in - 1'b1);

  vec_play_capture #(.W(W), .DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_sel     (load_sel),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .num_vec      (num_vec),
    .start        (start),
    .dut_in       (dut_in),
    .dut_valid    (dut_valid),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] stim_m [DEPTH];
  logic [W-1:0] exp_m  [DEPTH];
  logic [W-1:0] res_m  [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input logic sel, input int a, input logic [W-1:0] d);
    load_en = 1'b1; load_sel = sel; load_addr = AW'(a); load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (sel) exp_m[a] = d; else stim_m[a] = d;
  endtask

  task automatic check_results(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      #1;
      check(tag, rd_data, res_m[a]);
    end
  endtask

  // n: run length; inject: load+start during RUN; pre_ld: load stim[0]=pre_d
  // in the same cycle as start.
  task automatic run(input int n, input bit inject, input bit pre_ld, input logic [W-1:0] pre_d);
    int nc;
    int mm;
    int cyc;
    logic [W-1:0] r;
    logic [W-1:0] got;
    nc = (n > DEPTH) ? DEPTH : n;
    if (pre_ld) stim_m[0] = pre_d;
    mm = 0;
    for (int k = 0; k < nc; k++) begin
      exp_q.push_back(stim_m[k]);
      r = W'(stim_m[k] - 1'b1);
      res_m[k] = r;
      if (r != exp_m[k]) mm++;
    end
    if (pre_ld) begin
      load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = pre_d;
    end
    start = 1'b1; num_vec = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    cyc = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (dut_valid) begin
        check("busy_in_run", busy, 1);
        if (exp_q.size() == 0) begin
          check("vec_overrun", cyc + 1, nc);
        end else begin
          got = exp_q.pop_front();
          check("dut_in", dut_in, got);
        end
        cyc++;
        if (inject && cyc == 1) begin
          load_en = 1'b1; load_sel = 1'b0; load_addr = 2'd1; load_data = 2'd3;
          start = 1'b1; num_vec = 3'd1;
        end else if (inject && cyc == 2) begin
          load_en = 1'b0; start = 1'b0;
        end
      end else if (done) begin
        break;
      end
    end
    load_en = 1'b0; start = 1'b0;
    check("vec_count", cyc, nc);
    check("done", done, 1);
    check("busy_after", busy, 0);
    check("dut_in_idle", dut_in, 0);
    check("mismatch_cnt", mismatch_cnt, mm);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    check_results("rd_data");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      stim_m[a] = '0; exp_m[a] = '0; res_m[a] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", dut_valid, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_mm", mismatch_cnt, 0);
    check_results("rst_rd_data");

    // Full run, decrement datapath, no mismatches.
    for (int a = 0; a < DEPTH; a++) load(1'b0, a, W'(a));
    load(1'b1, 0, 2'd3); load(1'b1, 1, 2'd0); load(1'b1, 2, 2'd1); load(1'b1, 3, 2'd2);
    run(4, 1'b0, 1'b0, '0);

    // One wrong expected entry.
    load(1'b1, 3, 2'd1);
    run(4, 1'b0, 1'b0, '0);
    rd_addr = 2'd3; #1;
    check("rd3_after_mm", rd_data, 2);

    // Zero-length and partial runs.
    run(0, 1'b0, 1'b0, '0);
    run(2, 1'b0, 1'b0, '0);

    // Load and start during RUN are ignored; rerun shows stim[1] intact.
    run(4, 1'b1, 1'b0, '0);
    run(4, 1'b0, 1'b0, '0);

    // Oversized num_vec clamps to DEPTH.
    run(5, 1'b0, 1'b0, '0);

    // Reset on the second RUN cycle.
    start = 1'b1; num_vec = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) res_m[a] = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", dut_valid, 0);
    check("mid_rst_mm", mismatch_cnt, 0);
    check_results("mid_rst_rd_data");
    @(negedge clk);
    check("mid_rst_idle_hold", done, 0);

    // Load and start in the same IDLE cycle: run sees the new vector.
    run(1, 1'b0, 1'b1, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
